// File: rtl/hazard_pkg.sv
// Shared types for the load-use hazard scoreboard.
// Entry layout, cycle classification and default widths.
package hazard_pkg;

   localparam int REG_AW_DEF   = 5;
   localparam int LOAD_LAT_DEF = 2;
   // Widest register address an entry can hold; narrower ids are zero-extended.
   localparam int SB_AW        = 8;

   typedef struct packed {
      logic             valid;
      logic [SB_AW-1:0] rd;
   } sb_entry_t;

   typedef enum logic [2:0] {
      CL_RESET,
      CL_FREEZE,
      CL_FLUSH,
      CL_STALL,
      CL_RUN
   } cycle_cls_e;

   function automatic sb_entry_t mkEntry(
      input logic             v,
      input logic [SB_AW-1:0] r
   );
      sb_entry_t e;
      e.valid = v;
      e.rd    = r;
      return e;
   endfunction

   // Register zero is hardwired, so it never creates a dependency.
   function automatic logic entryHit(
      input sb_entry_t        e,
      input logic [SB_AW-1:0] r
   );
      return e.valid && (e.rd == r) && (r != '0);
   endfunction

endpackage

// File: rtl/load_scoreboard.sv
// Shift register of in-flight loads and the source-match lookup.
// Entry 0 is the youngest load; the oldest drops off on every shift.
module load_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW   = REG_AW_DEF,
   parameter int LOAD_LAT = LOAD_LAT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              shiftEn,
   input  logic              insValid,
   input  logic [REG_AW-1:0] insRd,
   input  logic [REG_AW-1:0] qRs,
   input  logic [REG_AW-1:0] qRt,
   output logic              rsAny,
   output logic              rtAny,
   output logic              rtYoung
);

   sb_entry_t sb [LOAD_LAT];

   logic [SB_AW-1:0] rsX;
   logic [SB_AW-1:0] rtX;

   assign rsX = SB_AW'(qRs);
   assign rtX = SB_AW'(qRt);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LOAD_LAT; i++) begin
            sb[i] <= '0;
         end
      end else if (shiftEn) begin
         sb[0] <= mkEntry(insValid, SB_AW'(insRd));
         for (int i = 1; i < LOAD_LAT; i++) begin
            sb[i] <= sb[i-1];
         end
      end
   end

   // Late rt consumers (store data) tolerate the oldest entry.
   always_comb begin
      rsAny   = 1'b0;
      rtAny   = 1'b0;
      rtYoung = 1'b0;
      for (int i = 0; i < LOAD_LAT; i++) begin
         rsAny = rsAny | entryHit(sb[i], rsX);
         rtAny = rtAny | entryHit(sb[i], rtX);
      end
      for (int i = 0; i < LOAD_LAT - 1; i++) begin
         rtYoung = rtYoung | entryHit(sb[i], rtX);
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard unit: stall/flush/freeze priority, stall counter
// and a sticky watchdog for runaway stalls.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW    = REG_AW_DEF,
   parameter int LOAD_LAT  = LOAD_LAT_DEF,
   parameter int CNT_W     = 4,
   parameter int MAX_STALL = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_rt_late,
   input  logic              id_is_load,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              ex_branch_taken,
   input  logic              mem_busy,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ctrl_mux,
   output logic              flush_ifid,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic              stall_timeout
);

   localparam logic [CNT_W-1:0] CNT_SAT   = '1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_STALL);

   logic       rsAny;
   logic       rtAny;
   logic       rtYoung;
   logic       hazard;
   logic       shiftEn;
   logic       insValid;
   cycle_cls_e cls;

   logic [CNT_W-1:0] cntNext;

   load_scoreboard #(
      .REG_AW  (REG_AW),
      .LOAD_LAT(LOAD_LAT)
   ) u_sb (
      .clk     (clk),
      .reset   (reset),
      .shiftEn (shiftEn),
      .insValid(insValid),
      .insRd   (id_rd),
      .qRs     (id_rs),
      .qRt     (id_rt),
      .rsAny   (rsAny),
      .rtAny   (rtAny),
      .rtYoung (rtYoung)
   );

   assign hazard = id_valid
                 & ((id_uses_rs & rsAny)
                 |  (id_uses_rt & (id_rt_late ? rtYoung : rtAny)));

   always_comb begin
      if (reset)                cls = CL_RESET;
      else if (mem_busy)        cls = CL_FREEZE;
      else if (ex_branch_taken) cls = CL_FLUSH;
      else if (hazard)          cls = CL_STALL;
      else                      cls = CL_RUN;
   end

   always_comb begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ctrl_mux   = 1'b0;
      flush_ifid = 1'b0;
      shiftEn    = 1'b0;
      insValid   = 1'b0;
      unique case (cls)
         CL_RESET: ;
         CL_FREEZE: begin
            ctrl_mux = 1'b1;
         end
         CL_FLUSH: begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            flush_ifid = 1'b1;
            shiftEn    = 1'b1;
         end
         CL_STALL: begin
            shiftEn = 1'b1;
         end
         CL_RUN: begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ctrl_mux   = 1'b1;
            shiftEn    = 1'b1;
            insValid   = id_valid & id_is_load & (id_rd != '0);
         end
         default: ;
      endcase
   end

   always_comb begin
      cntNext = '0;
      unique case (cls)
         CL_STALL:  cntNext = (stall_cycles == CNT_SAT)
                            ? stall_cycles : stall_cycles + 1'b1;
         CL_FREEZE: cntNext = stall_cycles;
         default:   cntNext = '0;
      endcase
   end

   // Watchdog rises on the same edge the counter reaches the limit.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles  <= '0;
         stall_timeout <= 1'b0;
      end else begin
         stall_cycles <= cntNext;
         if (cls == CL_STALL && cntNext >= CNT_LIMIT) begin
            stall_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector bench for hazard_scoreboard (LOAD_LAT=2 table,
// plus a LOAD_LAT=4 watchdog sequence).
module tb_hazard_scoreboard;

   typedef struct {
      logic       rst;
      logic       vld;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uRs;
      logic       uRt;
      logic       late;
      logic       ld;
      logic [4:0] rd;
      logic       br;
      logic       busy;
      logic [3:0] ctl;
      logic [3:0] cnt;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       idValid;
   logic [4:0] idRs;
   logic [4:0] idRt;
   logic       usesRs;
   logic       usesRt;
   logic       rtLate;
   logic       isLoad;
   logic [4:0] idRd;
   logic       brTaken;
   logic       memBusy;

   logic       pcW2, ifidW2, ctrl2, flush2, to2;
   logic [3:0] cnt2;
   logic       pcW4, ifidW4, ctrl4, flush4, to4;
   logic [3:0] cnt4;

   int nCmp = 0;
   int nBad = 0;

   hazard_scoreboard dut2 (
      .clk            (clk),
      .reset          (reset),
      .id_valid       (idValid),
      .id_rs          (idRs),
      .id_rt          (idRt),
      .id_uses_rs     (usesRs),
      .id_uses_rt     (usesRt),
      .id_rt_late     (rtLate),
      .id_is_load     (isLoad),
      .id_rd          (idRd),
      .ex_branch_taken(brTaken),
      .mem_busy       (memBusy),
      .pc_write       (pcW2),
      .ifid_write     (ifidW2),
      .ctrl_mux       (ctrl2),
      .flush_ifid     (flush2),
      .stall_cycles   (cnt2),
      .stall_timeout  (to2)
   );

   hazard_scoreboard #(
      .LOAD_LAT (4),
      .MAX_STALL(3)
   ) dut4 (
      .clk            (clk),
      .reset          (reset),
      .id_valid       (idValid),
      .id_rs          (idRs),
      .id_rt          (idRt),
      .id_uses_rs     (usesRs),
      .id_uses_rt     (usesRt),
      .id_rt_late     (rtLate),
      .id_is_load     (isLoad),
      .id_rd          (idRd),
      .ex_branch_taken(brTaken),
      .mem_busy       (memBusy),
      .pc_write       (pcW4),
      .ifid_write     (ifidW4),
      .ctrl_mux       (ctrl4),
      .flush_ifid     (flush4),
      .stall_cycles   (cnt4),
      .stall_timeout  (to4)
   );

   function automatic vec_t v(
      input logic       rst, vld,
      input logic [4:0] rs, rt,
      input logic       uRs, uRt, late, ld,
      input logic [4:0] rd,
      input logic       br, busy,
      input logic [3:0] ctl, cnt
   );
      vec_t t;
      t.rst = rst; t.vld = vld; t.rs = rs; t.rt = rt;
      t.uRs = uRs; t.uRt = uRt; t.late = late; t.ld = ld;
      t.rd = rd; t.br = br; t.busy = busy;
      t.ctl = ctl; t.cnt = cnt;
      return t;
   endfunction

   task automatic check(
      input string       name,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      reset   = t.rst;
      idValid = t.vld;
      idRs    = t.rs;
      idRt    = t.rt;
      usesRs  = t.uRs;
      usesRt  = t.uRt;
      rtLate  = t.late;
      isLoad  = t.ld;
      idRd    = t.rd;
      brTaken = t.br;
      memBusy = t.busy;
   endtask

   task automatic applyVec(input vec_t t, input int idx);
      drive(t);
      @(negedge clk);
      check($sformatf("v%0d.pc_write", idx),   32'(pcW2),   32'(t.ctl[3]));
      check($sformatf("v%0d.ifid_write", idx), 32'(ifidW2), 32'(t.ctl[2]));
      check($sformatf("v%0d.ctrl_mux", idx),   32'(ctrl2),  32'(t.ctl[1]));
      check($sformatf("v%0d.flush_ifid", idx), 32'(flush2), 32'(t.ctl[0]));
      @(posedge clk);
      #1;
      check($sformatf("v%0d.stall_cycles", idx), 32'(cnt2), 32'(t.cnt));
      check($sformatf("v%0d.stall_timeout", idx), 32'(to2), 32'd0);
   endtask

   vec_t tbl[$];
   vec_t ldR5;
   vec_t useR5;
   vec_t rstV;
   vec_t idleV;

   initial begin
      // rst vld rs rt uRs uRt late ld rd br busy ctl cnt
      tbl.push_back(v(1,1,5,5,1,1,0,1,5,1,1,4'b0000,0));
      tbl.push_back(v(1,0,0,0,0,0,0,0,0,0,0,4'b0000,0));
      // load r5 then rs=5 consumer: two stalls
      tbl.push_back(v(0,1,0,0,0,0,0,1,5,0,0,4'b1110,0));
      tbl.push_back(v(0,1,5,0,1,0,0,0,0,0,0,4'b0000,1));
      tbl.push_back(v(0,1,5,0,1,0,0,0,0,0,0,4'b0000,2));
      tbl.push_back(v(0,1,5,0,1,0,0,0,0,0,0,4'b1110,0));
      // late store data: one stall
      tbl.push_back(v(0,1,0,0,0,0,0,1,5,0,0,4'b1110,0));
      tbl.push_back(v(0,1,0,5,0,1,1,0,0,0,0,4'b0000,1));
      tbl.push_back(v(0,1,0,5,0,1,1,0,0,0,0,4'b1110,0));
      // early rt consumer: two stalls
      tbl.push_back(v(0,1,0,0,0,0,0,1,5,0,0,4'b1110,0));
      tbl.push_back(v(0,1,0,5,0,1,0,0,0,0,0,4'b0000,1));
      tbl.push_back(v(0,1,0,5,0,1,0,0,0,0,0,4'b0000,2));
      tbl.push_back(v(0,1,0,5,0,1,0,0,0,0,0,4'b1110,0));
      // r0 load, unused sources, invalid ID
      tbl.push_back(v(0,1,0,0,0,0,0,1,0,0,0,4'b1110,0));
      tbl.push_back(v(0,1,0,0,1,0,0,0,0,0,0,4'b1110,0));
      tbl.push_back(v(0,1,0,0,0,0,0,1,7,0,0,4'b1110,0));
      tbl.push_back(v(0,1,7,7,0,0,0,0,0,0,0,4'b1110,0));
      tbl.push_back(v(0,0,7,7,1,1,0,0,0,0,0,4'b1110,0));
      // branch overrides hazard; load survives the flush
      tbl.push_back(v(0,1,0,0,0,0,0,1,9,0,0,4'b1110,0));
      tbl.push_back(v(0,1,9,0,1,0,0,0,0,1,0,4'b1101,0));
      tbl.push_back(v(0,1,9,0,1,0,0,0,0,0,0,4'b0000,1));
      tbl.push_back(v(0,1,9,0,1,0,0,0,0,0,0,4'b1110,0));
      // mem_busy freezes a stall mid-way
      tbl.push_back(v(0,1,0,0,0,0,0,1,3,0,0,4'b1110,0));
      tbl.push_back(v(0,1,3,0,1,0,0,0,0,0,0,4'b0000,1));
      tbl.push_back(v(0,1,3,0,1,0,0,0,0,0,1,4'b0010,1));
      tbl.push_back(v(0,1,3,0,1,0,0,0,0,0,1,4'b0010,1));
      tbl.push_back(v(0,1,3,0,1,0,0,0,0,0,0,4'b0000,2));
      tbl.push_back(v(0,1,3,0,1,0,0,0,0,0,0,4'b1110,0));
      tbl.push_back(v(0,1,0,0,0,0,0,0,0,1,1,4'b0010,0));
      // reset during the stall discards the load
      tbl.push_back(v(0,1,0,0,0,0,0,1,5,0,0,4'b1110,0));
      tbl.push_back(v(1,1,5,0,1,0,0,0,0,0,0,4'b0000,0));
      tbl.push_back(v(0,1,5,0,1,0,0,0,0,0,0,4'b1110,0));

      drive(tbl[0]);
      foreach (tbl[i]) applyVec(tbl[i], i);

      // Watchdog on the LOAD_LAT=4 instance
      rstV  = v(1,0,0,0,0,0,0,0,0,0,0,4'b0000,0);
      ldR5  = v(0,1,0,0,0,0,0,1,5,0,0,4'b1110,0);
      useR5 = v(0,1,5,0,1,0,0,0,0,0,0,4'b0000,0);
      idleV = v(0,1,0,0,0,0,0,0,0,0,0,4'b1110,0);

      drive(rstV);
      @(posedge clk); #1;
      check("wd.reset_timeout", 32'(to4), 32'd0);

      drive(ldR5);
      @(negedge clk);
      check("wd.load_pc", 32'(pcW4), 32'd1);
      @(posedge clk); #1;

      for (int k = 1; k <= 4; k++) begin
         drive(useR5);
         @(negedge clk);
         check($sformatf("wd.stall%0d.pc", k),   32'(pcW4),   32'd0);
         check($sformatf("wd.stall%0d.ifid", k), 32'(ifidW4), 32'd0);
         check($sformatf("wd.stall%0d.ctrl", k), 32'(ctrl4),  32'd0);
         @(posedge clk); #1;
         check($sformatf("wd.stall%0d.cnt", k), 32'(cnt4), 32'(k));
         check($sformatf("wd.stall%0d.to", k), 32'(to4), 32'(k >= 3));
      end

      drive(useR5);
      @(negedge clk);
      check("wd.release.pc",    32'(pcW4),   32'd1);
      check("wd.release.flush", 32'(flush4), 32'd0);
      @(posedge clk); #1;
      check("wd.release.cnt", 32'(cnt4), 32'd0);
      check("wd.release.to",  32'(to4),  32'd1);

      for (int k = 0; k < 2; k++) begin
         drive(idleV);
         @(posedge clk); #1;
         check($sformatf("wd.sticky%0d", k), 32'(to4), 32'd1);
      end

      drive(rstV);
      @(posedge clk); #1;
      check("wd.cleared.to",  32'(to4),  32'd0);
      check("wd.cleared.cnt", 32'(cnt4), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register-address width.
REQ-002 SHALL have parameter LOAD_LAT, default 2, legal 1..4: consecutive cycles a load result is unavailable to an early consumer.
REQ-003 SHALL have parameter CNT_W, default 4: width of the stall counter.
REQ-004 SHALL have parameter MAX_STALL, default 3, legal 1..2^CNT_W-1: consecutive-stall limit for the watchdog.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high.
REQ-007 SHALL have port id_valid  in  1  IF/ID holds a real instruction.
REQ-008 SHALL have ports id_rs, id_rt  in  REG_AW  IF/ID source registers.
REQ-009 SHALL have ports id_uses_rs, id_uses_rt  in  1  source actually read.
REQ-010 SHALL have port id_rt_late  in  1  rt consumed in MEM, i.e. store data (word/half/byte).
REQ-011 SHALL have ports id_is_load  in  1, and id_rd  in  REG_AW  load destination.
REQ-012 SHALL have port ex_branch_taken  in  1  redirect resolved in EX.
REQ-013 SHALL have port mem_busy  in  1  global pipeline freeze.
REQ-014 SHALL have ports pc_write, ifid_write, ctrl_mux  out  1  (1 = advance/pass control, 0 = hold/bubble).
REQ-015 SHALL have ports flush_ifid  out  1, stall_cycles  out  CNT_W, and stall_timeout  out  1.

Function
REQ-016 SHALL keep a LOAD_LAT-entry shift register of {valid, rd}; entry 0 is youngest.
REQ-017 SHALL define match_any(r) as any valid entry with rd==r, and match_young(r) as the same over entries 0..LOAD_LAT-2 only (always false when LOAD_LAT=1); r==0 SHALL never match.
REQ-018 SHALL compute hazard = id_valid & ((id_uses_rs & match_any(id_rs)) | (id_uses_rt & (id_rt_late ? match_young(id_rt) : match_any(id_rt)))), combinationally in the same cycle.
REQ-019 SHALL apply priority 1, mem_busy: pc_write=0, ifid_write=0, ctrl_mux=1, flush_ifid=0; scoreboard and counter hold.
REQ-020 SHALL apply priority 2, ex_branch_taken: flush_ifid=1, ctrl_mux=0, pc_write=1, ifid_write=1; scoreboard shifts with an invalid entry inserted; a simultaneous hazard is ignored.
REQ-021 SHALL apply priority 3, hazard: pc_write=0, ifid_write=0, ctrl_mux=0, flush_ifid=0; scoreboard shifts with an invalid entry inserted.
REQ-022 SHALL apply priority 4, otherwise: all of pc_write, ifid_write, ctrl_mux = 1 and flush_ifid=0; shift inserting {id_valid & id_is_load & id_rd!=0, id_rd}.
REQ-023 SHALL drop the oldest entry on every shift; no entry is squashed by a branch flush, because entry 0 is the branch itself.
REQ-024 SHALL increment stall_cycles, saturating, on each priority-3 cycle, hold it under mem_busy, and clear it to 0 on priority-2 and priority-4 cycles.
REQ-025 SHALL set stall_timeout when stall_cycles reaches MAX_STALL; it is sticky until reset.

Reset
REQ-026 SHALL, on a clk edge with reset=1, clear all entries to invalid and set stall_cycles=0 and stall_timeout=0.
REQ-027 SHALL force pc_write=0, ifid_write=0, ctrl_mux=0 and flush_ifid=0 while reset=1, regardless of other inputs.
REQ-028 SHALL treat a reset asserted mid-stall as discarding all pending loads; the first post-reset cycle does not stall.

Structure
REQ-029 SHALL place the REG_AW and LOAD_LAT defaults and the sb_entry_t {valid, rd} typedef in shared package hazard_pkg.
REQ-030 SHALL implement the shift register and the match_any/match_young logic in sub-module load_scoreboard; priority, counter and watchdog logic stay in the top module.

Verification (LOAD_LAT=2 unless stated)
REQ-031 SHALL cover: load to r5 issued at cycle t, then ID add with rs=5 -> pc_write=ifid_write=ctrl_mux=0 at t+1 and t+2, all 1 at t+3; stall_cycles goes 1, 2, then 0.
REQ-032 SHALL cover: load to r5, then store with rt=5 and id_rt_late=1 -> exactly one stall cycle; with id_rt_late=0 -> two stall cycles.
REQ-033 SHALL cover: load to r0, then consumer with rs=0 -> no stall; id_uses_rs=0 with a matching rs -> no stall.
REQ-034 SHALL cover: hazard and ex_branch_taken in the same cycle -> flush_ifid=1, ctrl_mux=0, pc_write=1; mem_busy during a stall -> entries and stall_cycles frozen, stall resumes after release.
REQ-035 SHALL cover: reset pulsed at t+1 of the REQ-031 stall -> outputs 0 during reset, no stall after reset.
REQ-036 SHALL cover: LOAD_LAT=4, MAX_STALL=3 -> stall_timeout=1 on the third stall cycle and still 1 after the stall clears, until reset.
